// File: rtl/vend_pkg.sv
// Shared definitions for the multi-item vending controller.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VEND    = 2'd2,
    CHANGE  = 2'd3
  } state_e;

  // Coin values in 0.5-yuan credit units.
  localparam int COIN1_U  = 2;
  localparam int COIN10_U = 20;

endpackage

// File: rtl/vend_edge_det.sv
// Registered-delay edge detector; reports rising or falling edges on each bit.
module vend_edge_det #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0,
  parameter bit           FALL    = 1'b0
) (
  input  logic         cp,
  input  logic         rst,
  input  logic [W-1:0] in_i,
  output logic [W-1:0] evt_o
);

  logic [W-1:0] in_q;

  always_ff @(posedge cp or posedge rst) begin
    if (rst) in_q <= RST_VAL;
    else     in_q <= in_i;
  end

  assign evt_o = FALL ? (in_q & ~in_i) : (in_i & ~in_q);

endmodule

// File: rtl/vend_ctrl_multi.sv
// Multi-item vending controller: credit accumulation, per-item stock, change and timeout refund.
// state   | meaning
// IDLE    | waiting for start; restock accepted here only
// COLLECT | accepting coins / selects / cancel, idle timer running
// VEND    | one-cycle vend pulse, stock decrement, change computed
// CHANGE  | one-cycle change pulse, credit cleared
module vend_ctrl_multi
  import vend_pkg::*;
#(
  parameter int                            NUM_ITEMS   = 4,
  parameter int                            CREDIT_W    = 8,
  parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES      = {8'd20, 8'd15, 8'd10, 8'd5},
  parameter int                            MAX_CREDIT  = 40,
  parameter int                            STOCK_W     = 4,
  parameter int                            INIT_STOCK  = 3,
  parameter int                            TIMEOUT_CYC = 1000
) (
  input  logic                 cp,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 rmb1,
  input  logic                 rmb10,
  input  logic [NUM_ITEMS-1:0] sel,
  input  logic                 cancel_n,
  input  logic                 restock,
  output logic [CREDIT_W-1:0]  credit_o,
  output logic [CREDIT_W-1:0]  change_o,
  output logic                 change_vld,
  output logic                 vend_vld,
  output logic [2:0]           vend_item,
  output logic [NUM_ITEMS-1:0] sold_out,
  output logic                 err,
  output logic [1:0]           state_o
);

  localparam int CW1 = CREDIT_W + 1;
  localparam int TW  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC - 1);

  logic [1:0]           coin_rise;
  logic [NUM_ITEMS-1:0] sel_rise;
  logic                 start_evt, cancel_evt, restock_evt;

  vend_edge_det #(.W(2)) u_coin_edge (
    .cp(cp), .rst(rst), .in_i({rmb10, rmb1}), .evt_o(coin_rise));
  vend_edge_det #(.W(NUM_ITEMS)) u_sel_edge (
    .cp(cp), .rst(rst), .in_i(sel), .evt_o(sel_rise));
  vend_edge_det #(.W(1)) u_start_edge (
    .cp(cp), .rst(rst), .in_i(start), .evt_o(start_evt));
  vend_edge_det #(.W(1), .RST_VAL(1'b1), .FALL(1'b1)) u_cancel_edge (
    .cp(cp), .rst(rst), .in_i(cancel_n), .evt_o(cancel_evt));
  vend_edge_det #(.W(1)) u_restock_edge (
    .cp(cp), .rst(rst), .in_i(restock), .evt_o(restock_evt));

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d, change_q, change_d;
  logic [2:0]          item_q, item_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic                err_q, err_d;

  logic [CW1-1:0]      coin_add, credit_sum;
  logic                coin_evt, coin_ok, sel_evt, sel_multi, sel_sold;
  logic [2:0]          sel_idx;
  logic [CREDIT_W-1:0] sel_price, vend_price;

  assign coin_evt   = |coin_rise;
  assign coin_add   = (coin_rise[0] ? CW1'(COIN1_U)  : '0)
                    + (coin_rise[1] ? CW1'(COIN10_U) : '0);
  assign credit_sum = {1'b0, credit_q} + coin_add;
  assign coin_ok    = (credit_sum <= CW1'(MAX_CREDIT));
  assign sel_evt    = |sel_rise;
  assign sel_multi  = |(sel_rise & (sel_rise - NUM_ITEMS'(1)));

  always_comb begin
    sel_idx    = '0;
    sel_price  = '0;
    sel_sold   = 1'b0;
    vend_price = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (sel_rise[i]) begin
        sel_idx   = 3'(i);
        sel_price = PRICES[i*CREDIT_W +: CREDIT_W];
        sel_sold  = sold_out[i];
      end
      if (item_q == 3'(i)) vend_price = PRICES[i*CREDIT_W +: CREDIT_W];
    end
  end

  generate
    for (genvar g = 0; g < NUM_ITEMS; g++) begin : g_item
      logic [STOCK_W-1:0] stock_q;
      always_ff @(posedge cp or posedge rst) begin
        if (rst)                                   stock_q <= STOCK_W'(INIT_STOCK);
        else if (restock_evt && state_q == IDLE)   stock_q <= STOCK_W'(INIT_STOCK);
        else if (state_q == VEND && item_q == 3'(g) && stock_q != '0)
                                                   stock_q <= stock_q - STOCK_W'(1);
      end
      assign sold_out[g] = (stock_q == '0);
    end
  endgenerate

  always_ff @(posedge cp or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    change_d = change_q;
    item_d   = item_q;
    timer_d  = timer_q;
    err_d    = 1'b0;
    unique case (state_q)
      IDLE: if (start_evt) begin
        state_d  = COLLECT;
        credit_d = '0;
        timer_d  = TMAX;
      end
      COLLECT: begin
        if (cancel_evt) begin
          // A coin landing with the cancel is physically in the machine: refund it too.
          state_d  = CHANGE;
          change_d = credit_sum[CREDIT_W-1:0];
          credit_d = '0;
        end else begin
          if (coin_evt) begin
            if (coin_ok) credit_d = credit_sum[CREDIT_W-1:0];
            else         err_d    = 1'b1;
          end
          if (sel_evt) begin
            if (sel_multi || sel_sold || sel_price > credit_d) err_d = 1'b1;
            else begin
              item_d  = sel_idx;
              state_d = VEND;
            end
          end
          if (coin_evt || sel_evt) timer_d = TMAX;
          else if (timer_q == '0) begin
            state_d  = CHANGE;
            change_d = credit_q;
            credit_d = '0;
          end else timer_d = timer_q - TW'(1);
        end
      end
      VEND: begin
        state_d  = CHANGE;
        change_d = credit_q - vend_price;
        credit_d = '0;
      end
      CHANGE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge cp or posedge rst) begin
    if (rst) begin
      credit_q <= '0;
      change_q <= '0;
      item_q   <= '0;
      timer_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      credit_q <= credit_d;
      change_q <= change_d;
      item_q   <= item_d;
      timer_q  <= timer_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_o    = state_q;
    credit_o   = credit_q;
    change_o   = change_q;
    vend_item  = item_q;
    err        = err_q;
    vend_vld   = (state_q == VEND);
    change_vld = (state_q == CHANGE);
  end

endmodule
